// File: rtl/hbm_core_bridge_pkg.sv
// Shared constants and helpers for the HBM core bridge: read-flag position,
// controller tuser packing and statistics counter width.
package hbm_core_bridge_pkg;

    localparam int STAT_W    = 32;
    localparam int CMD_MAX_W = 64;

    // The read flag sits directly above the two reserved command bits.
    function automatic int rd_flag_pos(input int tuser_w);
        return tuser_w + 1;
    endfunction

    // Controller tuser = {read flag, address/length}; the reserved bits are dropped.
    function automatic logic [CMD_MAX_W-1:0] pack_tuser(input logic [CMD_MAX_W-1:0] cmd,
                                                        input int                   tuser_w);
        logic [CMD_MAX_W-1:0] addr_mask;
        logic [CMD_MAX_W-1:0] rd_flag;
        addr_mask = (CMD_MAX_W'(1) << (tuser_w - 1)) - CMD_MAX_W'(1);
        rd_flag   = (cmd >> (tuser_w + 1)) & CMD_MAX_W'(1);
        return (rd_flag << (tuser_w - 1)) | (cmd & addr_mask);
    endfunction

endpackage

// File: rtl/hbm_core_bridge_sync_fifo.sv
// Synchronous FIFO with registered storage and full/empty/occupancy flags.
// A push on a full FIFO is taken only when a pop happens in the same cycle.
module hbm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage carries no reset; pointers and occupancy alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/hbm_core_bridge.sv
// Bridge between a core command/data interface and an HBM controller AXIS pair,
// with read-credit flow control. Optional counters: define HBM_CORE_BRIDGE_STATS_EN.
module hbm_core_bridge
    import hbm_core_bridge_pkg::*;
#(
    parameter int C_M_AXIS_WR_TUSER_WIDTH = 23,
    parameter int C_M_AXIS_WR_TDATA_WIDTH = 1024,
    parameter int C_S_AXIS_RD_TDATA_WIDTH = 1024,
    parameter int CMD_FIFO_DEPTH          = 4,
    parameter int RD_FIFO_DEPTH           = 8
) (
    input  logic                                    ap_clk,
    input  logic                                    ap_rst_n,
    output logic                                    o_controller_ready,
    input  logic                                    i_command_valid,
    input  logic [C_M_AXIS_WR_TUSER_WIDTH+1:0]      i_command,
    input  logic [C_M_AXIS_WR_TDATA_WIDTH-1:0]      i_write_data,
    output logic                                    o_read_data_valid,
    input  logic                                    i_read_data_ready,
    output logic [C_S_AXIS_RD_TDATA_WIDTH-1:0]      o_read_data,
    output logic                                    m_axis_wr_tvalid,
    input  logic                                    m_axis_wr_tready,
    output logic [C_M_AXIS_WR_TDATA_WIDTH-1:0]      m_axis_wr_tdata,
    output logic [C_M_AXIS_WR_TUSER_WIDTH-1:0]      m_axis_wr_tuser,
    output logic [C_M_AXIS_WR_TDATA_WIDTH/8-1:0]    m_axis_wr_tkeep,
    output logic                                    m_axis_wr_tlast,
    input  logic                                    s_axis_rd_tvalid,
    output logic                                    s_axis_rd_tready,
    input  logic [C_S_AXIS_RD_TDATA_WIDTH-1:0]      s_axis_rd_tdata,
    input  logic [C_S_AXIS_RD_TDATA_WIDTH/8-1:0]    s_axis_rd_tkeep,
    input  logic                                    s_axis_rd_tlast,
    output logic [$clog2(RD_FIFO_DEPTH+1)-1:0]      o_rd_outstanding,
    output logic                                    o_err_unexpected_rd
`ifdef HBM_CORE_BRIDGE_STATS_EN
    ,
    output logic [STAT_W-1:0]                       o_stat_wr_cnt,
    output logic [STAT_W-1:0]                       o_stat_rd_cnt,
    output logic [STAT_W-1:0]                       o_stat_credit_stall_cnt
`endif
);

    localparam int TUSER_W    = C_M_AXIS_WR_TUSER_WIDTH;
    localparam int WDATA_W    = C_M_AXIS_WR_TDATA_WIDTH;
    localparam int CMD_W      = TUSER_W + 2;
    localparam int CMD_FIFO_W = CMD_W + WDATA_W;
    localparam int RD_FLAG    = rd_flag_pos(TUSER_W);
    localparam int OUT_W      = $clog2(RD_FIFO_DEPTH + 1);
    localparam int CMD_CNT_W  = $clog2(CMD_FIFO_DEPTH + 1);

    logic                  cmd_push;
    logic                  cmd_full;
    logic                  cmd_empty;
    logic [CMD_FIFO_W-1:0] cmd_head;
    logic [CMD_CNT_W-1:0]  cmd_count;
    logic [CMD_W-1:0]      head_cmd;
    logic                  head_is_rd;
    logic                  credit_ok;
    logic                  wr_hold;
    logic                  wr_hs;
    logic                  rd_issue;
    logic                  beat_hs;
    logic                  rd_dec;
    logic                  rd_pop;
    logic                  rd_full;
    logic                  rd_empty;
    logic [OUT_W-1:0]      rd_count;
    logic                  unused_inputs;

    // Command side: {command, write data} queued, head offered to the controller.
    assign o_controller_ready = ap_rst_n && !cmd_full;
    assign cmd_push           = i_command_valid && o_controller_ready;

    hbm_sync_fifo #(
        .WIDTH (CMD_FIFO_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .wr_en   (cmd_push),
        .wr_data ({i_command, i_write_data}),
        .rd_en   (wr_hs),
        .rd_data (cmd_head),
        .full    (cmd_full),
        .empty   (cmd_empty),
        .count   (cmd_count)
    );

    assign head_cmd   = cmd_head[CMD_FIFO_W-1 -: CMD_W];
    assign head_is_rd = head_cmd[RD_FLAG];

    // A read may only go out if its returning beat is guaranteed a buffer slot.
    assign credit_ok = ({1'b0, o_rd_outstanding} + {1'b0, rd_count}) < (OUT_W + 1)'(RD_FIFO_DEPTH);

    // wr_hold keeps an already-offered read valid even if an unexpected beat eats credit.
    assign m_axis_wr_tvalid = !cmd_empty && (!head_is_rd || credit_ok || wr_hold);
    assign m_axis_wr_tdata  = cmd_head[WDATA_W-1:0];
    assign m_axis_wr_tuser  = TUSER_W'(pack_tuser(CMD_MAX_W'(head_cmd), TUSER_W));
    assign m_axis_wr_tkeep  = '1;
    assign m_axis_wr_tlast  = 1'b0;

    assign wr_hs    = m_axis_wr_tvalid && m_axis_wr_tready;
    assign rd_issue = wr_hs && head_is_rd;

    // Read return side: every beat is buffered; tkeep/tlast carry no meaning here.
    assign s_axis_rd_tready  = ap_rst_n && !rd_full;
    assign beat_hs           = s_axis_rd_tvalid && s_axis_rd_tready;
    assign rd_dec            = beat_hs && (o_rd_outstanding != '0);
    assign o_read_data_valid = !rd_empty;
    assign rd_pop            = o_read_data_valid && i_read_data_ready;
    assign unused_inputs     = ^{cmd_count, s_axis_rd_tkeep, s_axis_rd_tlast};

    hbm_sync_fifo #(
        .WIDTH (C_S_AXIS_RD_TDATA_WIDTH),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .wr_en   (beat_hs),
        .wr_data (s_axis_rd_tdata),
        .rd_en   (rd_pop),
        .rd_data (o_read_data),
        .full    (rd_full),
        .empty   (rd_empty),
        .count   (rd_count)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_hold             <= 1'b0;
            o_rd_outstanding    <= '0;
            o_err_unexpected_rd <= 1'b0;
        end else begin
            wr_hold <= m_axis_wr_tvalid && !m_axis_wr_tready;
            if (rd_issue && !rd_dec)      o_rd_outstanding <= o_rd_outstanding + OUT_W'(1);
            else if (!rd_issue && rd_dec) o_rd_outstanding <= o_rd_outstanding - OUT_W'(1);
            if (beat_hs && (o_rd_outstanding == '0)) o_err_unexpected_rd <= 1'b1;
        end
    end

`ifdef HBM_CORE_BRIDGE_STATS_EN
    logic credit_stall;

    assign credit_stall = !cmd_empty && head_is_rd && !credit_ok && !wr_hold;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            o_stat_wr_cnt           <= '0;
            o_stat_rd_cnt           <= '0;
            o_stat_credit_stall_cnt <= '0;
        end else begin
            if (wr_hs && !head_is_rd) o_stat_wr_cnt <= o_stat_wr_cnt + STAT_W'(1);
            if (rd_issue)             o_stat_rd_cnt <= o_stat_rd_cnt + STAT_W'(1);
            if (credit_stall)         o_stat_credit_stall_cnt <= o_stat_credit_stall_cnt + STAT_W'(1);
        end
    end
`endif

endmodule

// File: doc/hbm_core_bridge.md
HBM_CORE_BRIDGE -- requirements
Module: hbm_core_bridge

Interface
REQ-001 SHALL take parameter C_M_AXIS_WR_TUSER_WIDTH, default 23, controller command width.
REQ-002 SHALL take parameter C_M_AXIS_WR_TDATA_WIDTH, default 1024, write data width.
REQ-003 SHALL take parameter C_S_AXIS_RD_TDATA_WIDTH, default 1024, read data width.
REQ-004 SHALL take parameter CMD_FIFO_DEPTH, default 4, command buffer entries; power of two, at least 2.
REQ-005 SHALL take parameter RD_FIFO_DEPTH, default 8, read data buffer entries; power of two, at least 2.
REQ-006 SHALL use one clock, ap_clk; reset ap_rst_n is asynchronous and active-low.
REQ-007 SHALL have ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  async active-low reset.
- o_controller_ready  out  1  command buffer not full.
- i_command_valid  in  1  command strobe.
- i_command  in  TUSER+2  bit TUSER+1 = read flag (1 = read); bits TUSER:TUSER-1 reserved; bits TUSER-2:0 = address/length.
- i_write_data  in  WDATA  write payload.
- o_read_data_valid  out  1  read beat available.
- i_read_data_ready  in  1  core accepts beat.
- o_read_data  out  RDATA  read beat.
- m_axis_wr_tvalid/tready/tdata/tuser/tkeep/tlast  AXIS master to controller (tkeep width WDATA/8).
- s_axis_rd_tvalid/tready/tdata/tkeep/tlast  AXIS slave from controller.
- o_rd_outstanding  out  clog2(RD_FIFO_DEPTH+1)  reads issued and not yet returned.
- o_err_unexpected_rd  out  1  sticky: beat received with zero outstanding.

Function
REQ-008 SHALL accept a command when i_command_valid and o_controller_ready are both high; o_controller_ready SHALL be high exactly when the command FIFO is not full.
REQ-009 SHALL store {i_command, i_write_data} in a registered FIFO; an accepted command SHALL reach m_axis_wr_tvalid no earlier than the next cycle.
REQ-010 SHALL drive m_axis_wr_tuser = {cmd[TUSER+1], cmd[TUSER-2:0]}, tkeep all ones, and tlast 0.
REQ-011 SHALL present a write at the FIFO head unconditionally.
REQ-012 SHALL present a read at the FIFO head only when o_rd_outstanding + read FIFO count < RD_FIFO_DEPTH (credit check).
REQ-013 SHALL hold m_axis_wr_tvalid high and tdata/tuser stable until the tready handshake once asserted.
REQ-014 SHALL increment o_rd_outstanding on each read command handshake and decrement it on each s_axis_rd handshake; simultaneous events SHALL leave it unchanged.
REQ-015 SHALL treat each read as returning exactly one beat; s_axis_rd_tkeep and s_axis_rd_tlast SHALL be ignored.
REQ-016 SHALL drive s_axis_rd_tready = not (read FIFO full).
REQ-017 SHALL accept a beat arriving while o_rd_outstanding = 0 without decrementing below 0, and SHALL set o_err_unexpected_rd.
REQ-018 SHALL present a buffered beat on o_read_data_valid the cycle after it is received, and pop it on the i_read_data_ready handshake.
REQ-019 SHALL allow push and pop on a full FIFO in the same cycle, and on an empty FIFO output only after the write.

Reset
REQ-020 SHALL set on reset: both FIFOs empty, o_controller_ready 1 (0 during reset assertion), m_axis_wr_tvalid 0, o_read_data_valid 0, s_axis_rd_tready 1 after release, o_rd_outstanding 0, and o_err_unexpected_rd 0.
REQ-021 SHALL discard buffered and in-flight state on reset mid-operation; the controller side is reset by the same reset.

Configuration
REQ-022 SHALL support macro HBM_CORE_BRIDGE_STATS_EN; when defined, SHALL add 32-bit outputs o_stat_wr_cnt, o_stat_rd_cnt, and o_stat_credit_stall_cnt.
- o_stat_credit_stall_cnt counts cycles in which a read at the head is blocked by REQ-012.
- These counters reset to 0 and wrap.
- When the macro is undefined, these ports and the logic SHALL be absent.

Structure
REQ-023 SHALL put the read-flag bit position, tuser packing function and stats width in package hbm_core_bridge_pkg.
REQ-024 SHALL instantiate a sub-module hbm_sync_fifo (parameterised width/depth, registered output, full/empty/count) twice.

Verification
REQ-025 SHALL cover: 4 writes back-to-back with tready=1 -> 4 tvalid beats starting cycle+1, tuser bits 24 and 21:0 preserved, and o_controller_ready never low.
REQ-026 SHALL cover: tready=0 and 5 commands offered -> 4 accepted and the 5th stalled with o_controller_ready=0 until one handshake occurs.
REQ-027 SHALL cover: 9 reads, no returns, i_read_data_ready=0 -> exactly 8 issued, o_rd_outstanding=8, and 9th held; 1 beat returned and popped -> 9th issues.
REQ-028 SHALL cover: read handshake and return beat in the same cycle -> o_rd_outstanding unchanged.
REQ-029 SHALL cover: beat injected with o_rd_outstanding=0 -> beat delivered, counter stays 0, and o_err_unexpected_rd=1 until reset.
REQ-030 SHALL cover: reset asserted with 3 commands and 2 beats buffered -> all valids 0 immediately, counters 0, and stats 0 when HBM_CORE_BRIDGE_STATS_EN is defined.
